// File: rtl/bank_word_packer.sv
// Packs a stream of pixels into bank-wide words and tags each word with
// its address within the bank; pix_last flushes a partial word early.
module bank_word_packer #(
    parameter int BLOCK_COUNT      = 4,
    parameter int BLOCK_DATA_WIDTH = 32,
    parameter int BANDWIDTH        = BLOCK_COUNT * BLOCK_DATA_WIDTH,
    parameter int PIXEL_WIDTH      = 16,
    parameter int ADDR_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [PIXEL_WIDTH-1:0] pix_data,
    input  logic                   pix_last,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [BANDWIDTH-1:0]   word_data,
    output logic [ADDR_WIDTH-1:0]  word_addr,
    output logic                   word_last
);

    localparam int PPW = BANDWIDTH / PIXEL_WIDTH;
    localparam int CW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(PPW - 1);

    logic [CW-1:0]         fill_cnt;
    logic [BANDWIDTH-1:0]  acc;
    logic [ADDR_WIDTH-1:0] next_addr;

    logic                  pix_fire;
    logic                  word_fire;
    logic                  close;
    logic [CW-1:0]         slot;
    logic [BANDWIDTH-1:0]  acc_base;
    logic [BANDWIDTH-1:0]  acc_merged;
    logic [ADDR_WIDTH-1:0] addr_base;

    // Handshake: a side transfers when valid && ready on a rising edge; valid
    // never waits on ready, and the output register frees up in the same
    // cycle it is consumed, so pixels keep flowing at one per cycle.
    assign pix_ready = !word_valid || word_ready;
    assign pix_fire  = pix_valid && pix_ready;
    assign word_fire = word_valid && word_ready;

    // frame_start makes the pixel of this very cycle slot 0 of a fresh word.
    always_comb begin
        slot       = frame_start ? '0 : fill_cnt;
        acc_base   = frame_start ? '0 : acc;
        addr_base  = frame_start ? '0 : next_addr;
        acc_merged = acc_base;
        acc_merged[int'(slot) * PIXEL_WIDTH +: PIXEL_WIDTH] = pix_data;
        close      = pix_fire && (pix_last || (slot == LAST_SLOT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_valid <= 1'b0;
            word_data  <= '0;
            word_addr  <= '0;
            word_last  <= 1'b0;
            fill_cnt   <= '0;
            acc        <= '0;
            next_addr  <= '0;
        end else begin
            if (close) begin
                word_valid <= 1'b1;
                word_data  <= acc_merged;
                word_addr  <= addr_base;
                word_last  <= pix_last;
            end else if (word_fire) begin
                word_valid <= 1'b0;
            end

            // The accumulator is zeroed on every close so flushed words carry zero pad.
            if (close) begin
                acc       <= '0;
                fill_cnt  <= '0;
                next_addr <= addr_base + 1'b1;
            end else if (pix_fire) begin
                acc       <= acc_merged;
                fill_cnt  <= slot + 1'b1;
                next_addr <= addr_base;
            end else if (frame_start) begin
                acc       <= '0;
                fill_cnt  <= '0;
                next_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bank_word_packer.sv
// Self-checking bench for bank_word_packer: a pixel-queue model checked every
// cycle, plus literal word expectations checked at each word transfer.
module tb_bank_word_packer;

    localparam int BW   = 128;
    localparam int PW   = 16;
    localparam int AW   = 8;
    localparam int PPW  = BW / PW;

    typedef struct {
        logic [BW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [PW-1:0] pix_data = '0;
    logic          pix_last = 1'b0;
    logic          word_valid;
    logic          word_ready = 1'b1;
    logic [BW-1:0] word_data;
    logic [AW-1:0] word_addr;
    logic          word_last;

    int checks = 0;
    int failures = 0;

    // model state
    logic          mv = 1'b0;
    logic [BW-1:0] md = '0;
    logic [AW-1:0] ma = '0;
    logic          ml = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [PW-1:0] pbuf[$];

    // literal expectations, consumed at each observed word transfer
    word_t         lit_q[$];
    logic          prev_v = 1'b0;
    logic [BW-1:0] prev_d = '0;
    logic [AW-1:0] prev_a = '0;
    logic          prev_l = 1'b0;

    bank_word_packer #(
        .BLOCK_COUNT(4),
        .BLOCK_DATA_WIDTH(32),
        .BANDWIDTH(BW),
        .PIXEL_WIDTH(PW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data(pix_data),
        .pix_last(pix_last),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_data(word_data),
        .word_addr(word_addr),
        .word_last(word_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk_word(input logic [PW-1:0] base);
        logic [BW-1:0] w;
        w = '0;
        for (int i = 0; i < PPW; i++) w[i*PW +: PW] = base + PW'(i);
        return w;
    endfunction

    task automatic push_lit(input logic [BW-1:0] d, input logic [AW-1:0] a, input logic l);
        word_t e;
        e.data = d;
        e.addr = a;
        e.last = l;
        lit_q.push_back(e);
    endtask

    // Inputs change only at negedge+1; the outputs settle before the next
    // negedge, where the model is advanced with the inputs of the edge just past.
    always @(negedge clk) begin
        logic  acc_p;
        word_t e;
        if (rst) begin
            mv = 1'b0; md = '0; ma = '0; ml = 1'b0; m_addr = '0;
            pbuf.delete();
        end else begin
            if (prev_v && word_ready && lit_q.size() > 0) begin
                e = lit_q.pop_front();
                chk("xfer_data", prev_d, e.data);
                chk("xfer_addr", BW'(prev_a), BW'(e.addr));
                chk("xfer_last", BW'(prev_l), BW'(e.last));
            end
            acc_p = pix_valid && (!mv || word_ready);
            if (mv && word_ready) mv = 1'b0;
            if (frame_start) begin
                pbuf.delete();
                m_addr = '0;
            end
            if (acc_p) begin
                pbuf.push_back(pix_data);
                if (pbuf.size() == PPW || pix_last) begin
                    md = '0;
                    for (int i = 0; i < pbuf.size(); i++) md[i*PW +: PW] = pbuf[i];
                    ma = m_addr;
                    ml = pix_last;
                    mv = 1'b1;
                    m_addr = m_addr + 1'b1;
                    pbuf.delete();
                end
            end
        end
        chk("word_valid", BW'(word_valid), BW'(mv));
        chk("pix_ready", BW'(pix_ready), BW'(!mv || word_ready));
        if (mv || rst) begin
            chk("word_data", word_data, md);
            chk("word_addr", BW'(word_addr), BW'(ma));
            chk("word_last", BW'(word_last), BW'(ml));
        end
        prev_v = rst ? 1'b0 : word_valid;
        prev_d = word_data;
        prev_a = word_addr;
        prev_l = word_last;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_pix(input logic [PW-1:0] d, input logic last, input logic fs);
        logic got;
        got = 1'b0;
        pix_valid = 1'b1;
        pix_data = d;
        pix_last = last;
        frame_start = fs;
        for (int t = 0; t < 64 && !got; t++) begin
            #3;
            got = pix_ready;
            @(negedge clk);
            #1;
            frame_start = 1'b0;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accepted pixel=%h", d);
        end
        pix_valid = 1'b0;
        pix_last = 1'($urandom_range(0, 1));
        pix_data = PW'($urandom);
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [PW-1:0] base);
        for (int j = 0; j < PPW; j++) send_pix(base + PW'(j), 1'b0, 1'b0);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // eight pixels fill one word, earliest pixel in the low slot
        push_lit(128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'd0, 1'b0);
        send_word(16'h0001);
        idle(2);

        // new frame, short line flushed by pix_last, then next address
        pulse_fs();
        push_lit(128'h0000_0000_0000_0000_0000_000C_000B_000A, 8'd0, 1'b1);
        send_pix(16'h000A, 1'b0, 1'b0);
        send_pix(16'h000B, 1'b0, 1'b0);
        send_pix(16'h000C, 1'b1, 1'b0);
        push_lit(128'h0018_0017_0016_0015_0014_0013_0012_0011, 8'd1, 1'b0);
        send_word(16'h0011);
        idle(2);

        // back-pressure: word held stable, pixel stalled until release
        word_ready = 1'b0;
        push_lit(mk_word(16'h0021), 8'd2, 1'b0);
        send_word(16'h0021);
        push_lit(mk_word(16'h0031), 8'd3, 1'b0);
        fork
            send_pix(16'h0031, 1'b0, 1'b0);
            begin
                idle(4);
                word_ready = 1'b1;
            end
        join
        for (int j = 1; j < PPW; j++) send_pix(16'h0031 + PW'(j), 1'b0, 1'b0);
        idle(2);

        // frame_start drops a partial word; its own pixel starts the new word
        for (int j = 0; j < 5; j++) send_pix(16'h0041 + PW'(j), 1'b0, 1'b0);
        push_lit(128'h0067_0066_0065_0064_0063_0062_0061_0055, 8'd0, 1'b0);
        send_pix(16'h0055, 1'b0, 1'b1);
        for (int j = 0; j < 7; j++) send_pix(16'h0061 + PW'(j), 1'b0, 1'b0);
        idle(2);

        // 257 back-to-back words: address wraps 255 -> 0
        pulse_fs();
        for (int w = 0; w < 257; w++) begin
            push_lit(mk_word(PW'(w * PPW + 1)), AW'(w), 1'b0);
            send_word(PW'(w * PPW + 1));
        end
        idle(3);

        // reset with a partial word accumulated
        for (int j = 0; j < 4; j++) send_pix(16'h0071 + PW'(j), 1'b0, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        push_lit(mk_word(16'h0081), 8'd0, 1'b0);
        send_word(16'h0081);
        idle(2);

        // reset with a word pending in the output register
        word_ready = 1'b0;
        send_word(16'h0091);
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        word_ready = 1'b1;
        push_lit(mk_word(16'h00A1), 8'd0, 1'b0);
        send_word(16'h00A1);
        idle(4);

        chk("lit_q_empty", BW'(lit_q.size()), BW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
